// File: rtl/step_clk_gen.sv
// Datapath clock source: a divided free-running clock, or exactly one pulse per
// debounced push-button press, plus a count of the rising edges issued.
`timescale 1ns/1ps
module step_clk_gen #(
  parameter int unsigned DIV_COUNT       = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned STEP_HIGH       = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        StepBtn,
  output logic        Clk_f,
  output logic        Running,
  output logic [15:0] CycleCount
);

  // The divider serves both the free-run half-period and the single-step high time.
  localparam int unsigned DIV_SPAN = (DIV_COUNT > STEP_HIGH) ? DIV_COUNT : STEP_HIGH;
  localparam int unsigned DIV_W    = $clog2(DIV_SPAN);
  localparam int unsigned DEB_W    = $clog2(DEBOUNCE_CYCLES);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV_COUNT - 1);
  localparam logic [DIV_W-1:0] STEP_LAST = DIV_W'(STEP_HIGH - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ONE   = DEB_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  logic             run_meta_q;
  logic             run_sync_q;
  logic             btn_meta_q;
  logic             btn_sync_q;

  logic [DEB_W-1:0] deb_cnt_q;
  logic [DEB_W-1:0] deb_cnt_d;
  logic             deb_lvl_q;
  logic             deb_lvl_d;
  logic             step_req_q;
  logic             step_req_d;

  state_e           state_q;
  state_e           state_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             clk_f_q;
  logic             clk_f_d;
  logic             running_q;
  logic             running_d;
  logic [15:0]      cycle_q;
  logic [15:0]      cycle_d;

  // Two-flop synchronizers for the asynchronous switch and button.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run_meta_q <= 1'b0;
      run_sync_q <= 1'b0;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
    end else begin
      run_meta_q <= Run;
      run_sync_q <= run_meta_q;
      btn_meta_q <= StepBtn;
      btn_sync_q <= btn_meta_q;
    end
  end

  // Debouncer: the level only moves after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    deb_cnt_d  = deb_cnt_q;
    deb_lvl_d  = deb_lvl_q;
    step_req_d = 1'b0;
    if (btn_sync_q != deb_lvl_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_lvl_d  = btn_sync_q;
        deb_cnt_d  = '0;
        step_req_d = btn_sync_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_ONE;
      end
    end else begin
      deb_cnt_d = '0;
    end
  end

  // Debouncer state and the registered one-cycle press request.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      deb_cnt_q  <= '0;
      deb_lvl_q  <= 1'b0;
      step_req_q <= 1'b0;
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      deb_lvl_q  <= deb_lvl_d;
      step_req_q <= step_req_d;
    end
  end

  // Mode FSM, divider and Clk_f next state; a free-run high phase always completes.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    clk_f_d = clk_f_q;
    case (state_q)
      ST_IDLE: begin
        clk_f_d = 1'b0;
        div_d   = '0;
        if (run_sync_q) begin
          state_d = ST_RUN;
        end else if (step_req_q) begin
          state_d = ST_STEP;
          clk_f_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (div_q == STEP_LAST) begin
          state_d = ST_IDLE;
          clk_f_d = 1'b0;
          div_d   = '0;
        end else begin
          clk_f_d = 1'b1;
          div_d   = div_q + DIV_ONE;
        end
      end
      ST_RUN: begin
        if (!run_sync_q && !clk_f_q) begin
          state_d = ST_IDLE;
          clk_f_d = 1'b0;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d   = '0;
          clk_f_d = ~clk_f_q;
          if (clk_f_q && !run_sync_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        clk_f_d = 1'b0;
        div_d   = '0;
      end
    endcase
    running_d = (state_d == ST_RUN);
    if (clk_f_d && !clk_f_q) begin
      cycle_d = cycle_q + 16'd1;
    end else begin
      cycle_d = cycle_q;
    end
  end

  // FSM, divider and output registers; every output comes straight from a flop.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      clk_f_q   <= 1'b0;
      running_q <= 1'b0;
      cycle_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      clk_f_q   <= clk_f_d;
      running_q <= running_d;
      cycle_q   <= cycle_d;
    end
  end

  assign Clk_f      = clk_f_q;
  assign Running    = running_q;
  assign CycleCount = cycle_q;

endmodule

// File: tb/tb_step_clk_gen.sv
// Self-checking bench for step_clk_gen: event-time reference model checked every
// cycle, a table of mode/button phases, and hand sequences for latency and reset.
`timescale 1ns/1ps
module tb_step_clk_gen;

  localparam int DIV = 4;
  localparam int DEB = 8;
  localparam int SH  = 3;

  logic        Clk     = 1'b0;
  logic        Reset   = 1'b1;
  logic        Run     = 1'b0;
  logic        StepBtn = 1'b0;
  logic        Clk_f;
  logic        Running;
  logic [15:0] CycleCount;

  step_clk_gen #(
    .DIV_COUNT      (DIV),
    .DEBOUNCE_CYCLES(DEB),
    .STEP_HIGH      (SH)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Run       (Run),
    .StepBtn   (StepBtn),
    .Clk_f     (Clk_f),
    .Running   (Running),
    .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit prev_clkf = 1'b0;
  bit rose = 1'b0;
  int rises = 0;

  // Reference model: synced inputs from a 2-deep sample history, Clk_f changes
  // scheduled as absolute edge numbers.
  int          m_cyc;
  bit          m_h_run[2];
  bit          m_h_btn[2];
  bit          m_lvl;
  int          m_streak;
  bit          m_req;
  int          m_mode;   // 0 idle, 1 single pulse, 2 free run
  bit          m_clk;
  int          m_next;
  logic [15:0] m_cnt;

  function automatic void model_reset();
    m_cyc = 0; m_h_run[0] = 1'b0; m_h_run[1] = 1'b0;
    m_h_btn[0] = 1'b0; m_h_btn[1] = 1'b0;
    m_lvl = 1'b0; m_streak = 0; m_req = 1'b0;
    m_mode = 0; m_clk = 1'b0; m_next = 0; m_cnt = 16'd0;
  endfunction

  function automatic void model_edge(input bit r, input bit b);
    bit s_run, s_btn, req;
    s_run = m_h_run[1];
    s_btn = m_h_btn[1];
    m_h_run[1] = m_h_run[0]; m_h_run[0] = r;
    m_h_btn[1] = m_h_btn[0]; m_h_btn[0] = b;
    req   = m_req;
    m_req = 1'b0;
    if (s_btn != m_lvl) begin
      m_streak++;
      if (m_streak == DEB) begin
        m_lvl = s_btn; m_streak = 0; m_req = s_btn;
      end
    end else begin
      m_streak = 0;
    end
    case (m_mode)
      0: if (s_run) begin
           m_mode = 2; m_next = m_cyc + DIV;
         end else if (req) begin
           m_mode = 1; m_clk = 1'b1; m_cnt = m_cnt + 16'd1; m_next = m_cyc + SH;
         end
      1: if (m_cyc == m_next) begin
           m_clk = 1'b0; m_mode = 0;
         end
      2: if (!s_run && !m_clk) begin
           m_mode = 0;
         end else if (m_cyc == m_next) begin
           m_clk  = !m_clk;
           m_next = m_next + DIV;
           if (m_clk) m_cnt = m_cnt + 16'd1;
           else if (!s_run) m_mode = 0;
         end
      default: ;
    endcase
    m_cyc++;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // One board-clock cycle: drive, advance model at the edge, compare 1ns later.
  task automatic cyc(input bit r, input bit b);
    Run = r; StepBtn = b;
    @(posedge Clk);
    model_edge(r, b);
    #1;
    chk("clk_f",   {31'd0, Clk_f},   {31'd0, m_clk});
    chk("running", {31'd0, Running}, {31'd0, (m_mode == 2)});
    chk("count",   {16'd0, CycleCount}, {16'd0, m_cnt});
    rose = !prev_clkf && (Clk_f === 1'b1);
    if (rose) rises++;
    prev_clkf = (Clk_f === 1'b1);
  endtask

  task automatic do_reset();
    Reset = 1'b1; Run = 1'b0; StepBtn = 1'b0;
    model_reset();
    prev_clkf = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_clk_f",   {31'd0, Clk_f},   32'd0);
    chk("rst_running", {31'd0, Running}, 32'd0);
    chk("rst_count",   {16'd0, CycleCount}, 32'd0);
    Reset = 1'b0;
  endtask

  // Alternating segments of 1..5 cycles, always ending on the level opposite to 'first'.
  task automatic bounce(input bit first, input int total);
    int t = 0;
    while (t < total) begin
      int a = int'($urandom_range(1, 5));
      int b = int'($urandom_range(1, 5));
      repeat (a) cyc(1'b0, first);
      repeat (b) cyc(1'b0, !first);
      t += a + b;
    end
  endtask

  typedef struct {
    bit run;
    bit btn;
    int n;
    int exp_rises;
    bit exp_running;
  } vec_t;

  vec_t tbl[9];
  bit   hist[41];

  initial begin
    int first_k, second_k, hi, r0;

    tbl[0] = '{1'b0, 1'b1, 20, 1, 1'b0};  // clean press: one pulse
    tbl[1] = '{1'b0, 1'b0, 20, 0, 1'b0};  // release: nothing
    tbl[2] = '{1'b1, 1'b0, 23, 3, 1'b1};  // free run: rises at 6,14,22
    tbl[3] = '{1'b1, 1'b1, 20, 2, 1'b1};  // press during run ignored
    tbl[4] = '{1'b1, 1'b0, 16, 2, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 16, 0, 1'b0};  // stop while low
    tbl[6] = '{1'b0, 1'b1,  9, 0, 1'b0};
    tbl[7] = '{1'b1, 1'b1,  7, 1, 1'b1};  // Run seen during the pulse waits for IDLE
    tbl[8] = '{1'b1, 1'b1,  4, 1, 1'b1};

    do_reset();

    // Free-run latency, period and duty.
    for (int k = 1; k <= 40; k++) begin
      cyc(1'b1, 1'b0);
      hist[k] = (Clk_f === 1'b1);
    end
    first_k = 0; second_k = 0; hi = 0;
    for (int k = 1; k <= 40; k++) begin
      if (hist[k] && !hist[k-1]) begin
        if (first_k == 0) first_k = k;
        else if (second_k == 0) second_k = k;
      end
    end
    for (int k = 1; k <= 40; k++)
      if (k >= first_k && k < second_k && hist[k]) hi++;
    chk("run_first_rise", first_k, 7);
    chk("run_period", second_k - first_k, 8);
    chk("run_high_width", hi, 4);

    // Run dropped one cycle after a rise: high phase completes, then IDLE.
    r0 = rises;
    for (int k = 0; k < 20 && rises == r0; k++) cyc(1'b1, 1'b0);
    chk("drop_saw_rise", rises - r0, 1);
    hi = 1;
    cyc(1'b1, 1'b0);
    if (Clk_f === 1'b1) hi++;
    for (int k = 0; k < 20 && Clk_f === 1'b1; k++) begin
      cyc(1'b0, 1'b0);
      if (Clk_f === 1'b1) hi++;
    end
    chk("drop_high_width", hi, 4);
    r0 = rises;
    repeat (30) cyc(1'b0, 1'b0);
    chk("drop_no_edges", rises - r0, 0);
    chk("drop_running", {31'd0, Running}, 32'd0);

    // Table of mode/button phases applied back to back.
    for (int i = 0; i < 9; i++) begin
      r0 = rises;
      repeat (tbl[i].n) cyc(tbl[i].run, tbl[i].btn);
      chk($sformatf("vec%0d_rises", i), rises - r0, tbl[i].exp_rises);
      chk($sformatf("vec%0d_running", i), {31'd0, Running}, {31'd0, tbl[i].exp_running});
    end

    // Bouncy press then bouncy release.
    repeat (25) cyc(1'b0, 1'b0);
    r0 = rises;
    bounce(1'b1, 30);
    chk("bounce_press_quiet", rises - r0, 0);
    first_k = 0;
    for (int k = 1; k <= 25; k++) begin
      cyc(1'b0, 1'b1);
      if (rose && first_k == 0) first_k = k;
    end
    chk("bounce_press_latency", first_k, 11);
    chk("bounce_press_pulses", rises - r0, 1);
    r0 = rises;
    bounce(1'b0, 30);
    repeat (25) cyc(1'b0, 1'b0);
    chk("bounce_release_pulses", rises - r0, 0);

    // Random phases against the model.
    begin
      int rl = 0, bl = 0;
      bit r = 1'b0, b = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if (rl == 0) begin
          r  = ($urandom_range(0, 2) == 0);
          rl = int'($urandom_range(5, 80));
        end
        if (bl == 0) begin
          b  = !b;
          bl = int'($urandom_range(1, 25));
        end
        rl--; bl--;
        cyc(r, b);
      end
    end

    // Counter wrap.
    repeat (40) cyc(1'b0, 1'b0);
    m_cnt = 16'hFFFE;
    force dut.cycle_q = 16'hFFFE;
    cyc(1'b0, 1'b0);
    release dut.cycle_q;
    repeat (20) cyc(1'b0, 1'b1);
    repeat (20) cyc(1'b0, 1'b0);
    chk("count_ffff", {16'd0, CycleCount}, 32'h0000FFFF);
    repeat (20) cyc(1'b0, 1'b1);
    repeat (20) cyc(1'b0, 1'b0);
    chk("count_wrap", {16'd0, CycleCount}, 32'h00000000);

    // Asynchronous reset in the middle of a single-step pulse.
    for (int k = 0; k < 20 && Clk_f !== 1'b1; k++) cyc(1'b0, 1'b1);
    chk("async_step_high", {31'd0, Clk_f}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("async_step_clk_f", {31'd0, Clk_f}, 32'd0);
    chk("async_step_count", {16'd0, CycleCount}, 32'd0);
    model_reset();
    prev_clkf = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    r0 = rises;
    repeat (20) cyc(1'b0, 1'b0);
    chk("async_no_pending", rises - r0, 0);

    // Asynchronous reset during a free-run high phase.
    for (int k = 0; k < 20 && Clk_f !== 1'b1; k++) cyc(1'b1, 1'b0);
    #2 Reset = 1'b1;
    #1;
    chk("async_run_clk_f",   {31'd0, Clk_f},   32'd0);
    chk("async_run_running", {31'd0, Running}, 32'd0);
    chk("async_run_count",   {16'd0, CycleCount}, 32'd0);
    model_reset();
    prev_clkf = 1'b0;
    Run = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (10) cyc(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/step_clk_gen.md
Name: step_clk_gen

Overview:
- Upstream clock source for the pipelined datapath. Generates the slow datapath clock Clk_f from the board clock.
- Two modes, selected by a switch:
  - free-run: Clk_f is the board clock divided down.
  - single-step: each debounced button press produces exactly one Clk_f pulse.
- Also counts the Clk_f rising edges it has issued, so the display can show the cycle number.

Parameters:
- DIV_COUNT, 50000000, board-clock cycles per Clk_f half-period in free-run mode (must be ≥2).
- DEBOUNCE_CYCLES, 1000000, consecutive stable board-clock cycles required before the debounced button level changes (must be ≥2).
- STEP_HIGH, 16, board-clock cycles Clk_f stays high for one single-step pulse (must be ≥1).

Ports:
- Clk  input  1  board clock; the only clock in the block.
- Reset  input  1  asynchronous, active-high reset.
- Run  input  1  mode switch, asynchronous: 1 = free-run, 0 = single-step.
- StepBtn  input  1  step push-button, asynchronous and bouncy.
- Clk_f  output  1  generated datapath clock; driven directly from a flop, no combinational glitches.
- Running  output  1  high while the FSM is in state RUN.
- CycleCount  output  16  number of Clk_f rising edges since reset.

Behaviour:
- Reset (asynchronous, active-high) clears everything: FSM=IDLE, Clk_f=0, Running=0, CycleCount=0, divider=0, debounce counter=0, debounced level=0, all synchronizer flops=0.
- Synchronizers: Run and StepBtn each pass through a 2-flop synchronizer before any use. Only the synchronized values are referenced below.
- Debouncer:
  - Counter increments while the synced button differs from the debounced level.
  - Counter clears to 0 on any cycle where they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the synced value on that edge and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change the debounced level.
- StepReq: a one-cycle pulse on the debounced level's 0→1 transition. Releases produce nothing.
- FSM:
  - IDLE:
    - Clk_f=0.
    - If syncRun=1: go to RUN and clear the divider. syncRun has priority over a StepReq in the same cycle.
    - Else if StepReq: go to STEP, clear the divider, and drive Clk_f=1 on the same edge.
  - STEP:
    - Clk_f=1. Divider counts up.
    - When the divider reaches STEP_HIGH-1: Clk_f=0, return to IDLE.
    - StepReq and Run changes are ignored until back in IDLE.
  - RUN:
    - Divider counts 0..DIV_COUNT-1.
    - At terminal count: toggle Clk_f and clear the divider.
    - First rising edge of Clk_f comes DIV_COUNT cycles after entry.
    - StepReq is ignored.
  - RUN with syncRun=0:
    - If Clk_f=0: go to IDLE immediately.
    - If Clk_f=1: keep dividing until the next terminal count drives Clk_f=0, then go to IDLE on that same edge. The high phase is never truncated.
- Running = (state==RUN), registered.
- CycleCount:
  - Increments by 1 on every edge where the Clk_f register goes 0→1, in either mode.
  - Wraps 16'hFFFF→16'h0000 with no flag.
- Step latency: first sampled-high edge of StepBtn to Clk_f=1 is exactly 2 (sync) + DEBOUNCE_CYCLES + 1 (StepReq → FSM) board-clock cycles.
- Reset asserted mid-pulse or mid-debounce: all outputs return to their reset values asynchronously. After release the block starts in IDLE with no pending step.

Test Plan (bench parameters: DIV_COUNT=4, DEBOUNCE_CYCLES=8, STEP_HIGH=3):
- Reset, then Run=1 held → Clk_f period is 8 Clk cycles at 50% duty, first rise 2+1+4 cycles after Run rises; CycleCount = 1,2,3... on each rise; Running=1.
- Run=0, clean StepBtn press held 20 cycles → exactly one Clk_f pulse, high for 3 cycles, rising 11 cycles after StepBtn; CycleCount +1; Running=0.
- StepBtn bouncing (pulses of 1–5 cycles for 30 cycles, then stable high) → exactly one Clk_f pulse, starting after the final stable period; releasing the button with bounce adds no pulse.
- Run dropped 1 cycle after Clk_f rises in free-run → Clk_f stays high its full 4 cycles, falls, FSM goes to IDLE, Running=0, no further edges.
- Button press during STEP, and during RUN → ignored: no extra Clk_f pulse, CycleCount unchanged by the press.
- Force CycleCount to 16'hFFFF via stepping (or a long run) → next rise gives 16'h0000. Reset asserted while Clk_f=1 → Clk_f=0, CycleCount=0 immediately, without waiting for a clock edge.
